// File: rtl/riscv_fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: the queue entry layout
// and the NOP substituted for faulting fetches.
package riscv_fetch_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_queue_if.sv
// Fetch-to-decode port bundle: redirect request in, instruction stream out.
// Handshake: an entry transfers on a rising edge where inst_valid_o && inst_ready_i;
// while inst_valid_o=1 and inst_ready_i=0 the head outputs hold steady.
interface riscv_fetch_queue_if #(
  parameter int Q_DEPTH = 4
);
  localparam int CW = $clog2(Q_DEPTH) + 1;

  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          inst_ready_i;
  logic          inst_valid_o;
  logic [31:0]   inst_o;
  logic [31:0]   inst_pc_o;
  logic [31:0]   inst_pc4_o;
  logic          fault_o;
  logic [CW-1:0] count_o;

  // master: the fetch queue; slave: decode
  modport master (
    input  redirect_i, redirect_pc_i, inst_ready_i,
    output inst_valid_o, inst_o, inst_pc_o, inst_pc4_o, fault_o, count_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, inst_ready_i,
    input  inst_valid_o, inst_o, inst_pc_o, inst_pc4_o, fault_o, count_o
  );
endinterface

// File: rtl/riscv_fetch_queue_fifo.sv
// Circular buffer of fetch entries with flush. Storage is cleared on reset so
// the head reads as zero (never X) before the first push.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  assign dout = mem[rd_ptr];

  // When full with a pop, wr_ptr == rd_ptr: the popped slot is rewritten as the new tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/riscv_fetch_queue.sv
// Fetch front end: PC generator and instruction-table reader feeding a prefetch
// queue. Out-of-range or misaligned fetches become a single fault entry and halt fetch.
module riscv_fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int          N_INST   = 21,
  parameter int          Q_DEPTH  = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tab_inst [N_INST],
  riscv_fetch_queue_if.master bus
);

  localparam int CW = $clog2(Q_DEPTH) + 1;
  localparam int IW = (N_INST > 1) ? $clog2(N_INST) : 1;

  logic [31:0]   fpc;
  logic          halted;
  logic [29:0]   idx;
  logic          bad;
  logic [31:0]   rd_inst;
  logic          push;
  logic          pop;
  logic          valid;
  logic [CW-1:0] count;
  fetch_entry_t  din;
  fetch_entry_t  dout;

  assign idx = fpc[31:2];
  assign bad = (fpc[1:0] != 2'b00) || ({2'b00, idx} >= 32'(N_INST));

  // Index only in range so the table is never read past its end.
  always_comb begin
    rd_inst = RV_NOP;
    if (!bad) rd_inst = tab_inst[idx[IW-1:0]];
  end

  assign din   = '{inst: rd_inst, pc: fpc, fault: bad};
  assign valid = (count != '0) && !bus.redirect_i;
  assign pop   = valid && bus.inst_ready_i;
  assign push  = !halted && ((count < CW'(Q_DEPTH)) || pop) && !bus.redirect_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc    <= RESET_PC;
      halted <= 1'b0;
    end else if (bus.redirect_i) begin
      fpc    <= bus.redirect_pc_i;
      halted <= 1'b0;
    end else if (push) begin
      fpc <= fpc + 32'd4;
      if (bad) halted <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_i),
    .din   (din),
    .dout  (dout),
    .count (count)
  );

  assign bus.inst_valid_o = valid;
  assign bus.inst_o       = dout.inst;
  assign bus.inst_pc_o    = dout.pc;
  assign bus.inst_pc4_o   = dout.pc + 32'd4;
  assign bus.fault_o      = dout.fault;
  assign bus.count_o      = count;

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: reset, streaming, backpressure,
// redirect, running off the table end, misaligned redirect and async reset.
module tb_riscv_fetch_queue;

  localparam int N_INST  = 21;
  localparam int Q_DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] tab [N_INST];
  int          total;
  int          bad;

  riscv_fetch_queue_if #(.Q_DEPTH(Q_DEPTH)) bus ();

  riscv_fetch_queue #(
    .N_INST   (N_INST),
    .Q_DEPTH  (Q_DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tab_inst (tab),
    .bus      (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input logic rdy);
    rst              = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.inst_ready_i  = rdy;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = pc;
    @(negedge clk);
    bus.redirect_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.inst_ready_i  = 1'b0;
    @(negedge clk);
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.inst_valid_o); end
    total++; if (bus.fault_o !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", bus.fault_o); end
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.inst_o !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", bus.inst_o); end
    total++; if (bus.inst_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.inst_pc_o); end
    total++; if (bus.inst_pc4_o !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h exp=4", bus.inst_pc4_o); end
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    #1;
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL stream_cycle1_valid got=%b exp=0", bus.inst_valid_o); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, bus.inst_valid_o); end
      total++; if (bus.inst_pc_o !== 32'(4*k)) begin bad++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, bus.inst_pc_o, 32'(4*k)); end
      total++; if (bus.inst_pc4_o !== 32'(4*k+4)) begin bad++; $display("FAIL stream_pc4 k=%0d got=%h exp=%h", k, bus.inst_pc4_o, 32'(4*k+4)); end
      total++; if (bus.inst_o !== tab[k]) begin bad++; $display("FAIL stream_inst k=%0d got=%h exp=%h", k, bus.inst_o, tab[k]); end
    end
  endtask

  task automatic test_backpressure;
    do_reset(1'b0);
    repeat (10) @(negedge clk);
    total++; if (bus.count_o !== 3'd4) begin bad++; $display("FAIL bp_count got=%0d exp=4", bus.count_o); end
    total++; if (bus.inst_pc_o !== 32'h0) begin bad++; $display("FAIL bp_head_pc got=%h exp=0", bus.inst_pc_o); end
    bus.inst_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid k=%0d got=%b exp=1", k, bus.inst_valid_o); end
      total++; if (bus.inst_pc_o !== 32'(4*k)) begin bad++; $display("FAIL bp_pc k=%0d got=%h exp=%h", k, bus.inst_pc_o, 32'(4*k)); end
      total++; if (bus.inst_o !== tab[k]) begin bad++; $display("FAIL bp_inst k=%0d got=%h exp=%h", k, bus.inst_o, tab[k]); end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    total++; if (bus.count_o !== 3'd3) begin bad++; $display("FAIL redir_pre_count got=%0d exp=3", bus.count_o); end
    bus.inst_ready_i  = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h20;
    #1;
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL redir_cycle_valid got=%b exp=0", bus.inst_valid_o); end
    @(negedge clk);
    bus.redirect_i = 1'b0;
    #1;
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL redir_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL redir_next_valid got=%b exp=0", bus.inst_valid_o); end
    @(negedge clk);
    total++; if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL redir_head_valid got=%b exp=1", bus.inst_valid_o); end
    total++; if (bus.inst_pc_o !== 32'h20) begin bad++; $display("FAIL redir_head_pc got=%h exp=20", bus.inst_pc_o); end
    total++; if (bus.inst_o !== tab[8]) begin bad++; $display("FAIL redir_head_inst got=%h exp=%h", bus.inst_o, tab[8]); end
    total++; if (bus.fault_o !== 1'b0) begin bad++; $display("FAIL redir_head_fault got=%b exp=0", bus.fault_o); end
  endtask

  task automatic test_run_off_end;
    redirect_to(32'h40);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++; if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL end_valid k=%0d got=%b exp=1", k, bus.inst_valid_o); end
      total++; if (bus.inst_pc_o !== 32'(32'h40 + 4*k)) begin bad++; $display("FAIL end_pc k=%0d got=%h exp=%h", k, bus.inst_pc_o, 32'(32'h40 + 4*k)); end
      if (k < 5) begin
        total++; if (bus.inst_o !== tab[16+k]) begin bad++; $display("FAIL end_inst k=%0d got=%h exp=%h", k, bus.inst_o, tab[16+k]); end
        total++; if (bus.fault_o !== 1'b0) begin bad++; $display("FAIL end_fault k=%0d got=%b exp=0", k, bus.fault_o); end
      end else begin
        total++; if (bus.inst_o !== 32'h0000_0013) begin bad++; $display("FAIL end_nop got=%h exp=00000013", bus.inst_o); end
        total++; if (bus.fault_o !== 1'b1) begin bad++; $display("FAIL end_fault_last got=%b exp=1", bus.fault_o); end
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL end_halted_valid k=%0d got=%b exp=0", k, bus.inst_valid_o); end
      total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL end_halted_count k=%0d got=%0d exp=0", k, bus.count_o); end
    end
    redirect_to(32'h0);
    @(negedge clk);
    total++; if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL resume_valid got=%b exp=1", bus.inst_valid_o); end
    total++; if (bus.inst_pc_o !== 32'h0) begin bad++; $display("FAIL resume_pc got=%h exp=0", bus.inst_pc_o); end
    total++; if (bus.inst_o !== tab[0]) begin bad++; $display("FAIL resume_inst got=%h exp=%h", bus.inst_o, tab[0]); end
    @(negedge clk);
    total++; if (bus.inst_pc_o !== 32'h4) begin bad++; $display("FAIL resume_pc2 got=%h exp=4", bus.inst_pc_o); end
  endtask

  task automatic test_misaligned;
    bus.inst_ready_i = 1'b1;
    redirect_to(32'h6);
    @(negedge clk);
    total++; if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL mis_valid got=%b exp=1", bus.inst_valid_o); end
    total++; if (bus.fault_o !== 1'b1) begin bad++; $display("FAIL mis_fault got=%b exp=1", bus.fault_o); end
    total++; if (bus.inst_pc_o !== 32'h6) begin bad++; $display("FAIL mis_pc got=%h exp=6", bus.inst_pc_o); end
    total++; if (bus.inst_pc4_o !== 32'hA) begin bad++; $display("FAIL mis_pc4 got=%h exp=a", bus.inst_pc4_o); end
    total++; if (bus.inst_o !== 32'h0000_0013) begin bad++; $display("FAIL mis_inst got=%h exp=00000013", bus.inst_o); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL mis_halted k=%0d got=%b exp=0", k, bus.inst_valid_o); end
    end
  endtask

  task automatic test_async_reset;
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    total++; if (bus.count_o !== 3'd4) begin bad++; $display("FAIL ar_pre_count got=%0d exp=4", bus.count_o); end
    total++; if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b exp=1", bus.inst_valid_o); end
    // pending redirect at the moment reset hits must be discarded
    #2;
    bus.redirect_pc_i = 32'h30;
    rst = 1'b1;
    #1;
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", bus.inst_valid_o); end
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.inst_o !== 32'h0) begin bad++; $display("FAIL ar_inst got=%h exp=0", bus.inst_o); end
    total++; if (bus.inst_pc_o !== 32'h0) begin bad++; $display("FAIL ar_pc got=%h exp=0", bus.inst_pc_o); end
    total++; if (bus.inst_pc4_o !== 32'h4) begin bad++; $display("FAIL ar_pc4 got=%h exp=4", bus.inst_pc4_o); end
    total++; if (bus.fault_o !== 1'b0) begin bad++; $display("FAIL ar_fault got=%b exp=0", bus.fault_o); end
    @(negedge clk);
    bus.inst_ready_i = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL ar_restart_valid got=%b exp=1", bus.inst_valid_o); end
    total++; if (bus.inst_pc_o !== 32'h0) begin bad++; $display("FAIL ar_restart_pc got=%h exp=0", bus.inst_pc_o); end
    total++; if (bus.inst_o !== tab[0]) begin bad++; $display("FAIL ar_restart_inst got=%h exp=%h", bus.inst_o, tab[0]); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tab[0] = 32'h0050_0093;
    tab[1] = 32'h0010_0113;
    tab[2] = 32'h0020_81B3;
    tab[3] = 32'h0000_0013;
    for (int i = 4; i < N_INST; i++) tab[i] = 32'h1000_0000 + 32'(i);

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_run_off_end();
    test_misaligned();
    test_async_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_queue.md
# riscv_fetch_queue

Parametrised instruction-fetch front end for the RISC-V core. It replaces the bare PC register plus `pc>>2` table lookup with a PC generator and an instruction-table reader. A Q_DEPTH-entry prefetch queue sits between them and decode, which consumes it through a valid/ready handshake. Branch/jump redirect flushes the queue, and fetches that are out of range or misaligned are flagged rather than wrapping silently.

## Interface
- N_INST, default 21: number of 32-bit words in the instruction table.
- Q_DEPTH, default 4: prefetch queue depth; power of two, ≥ 2.
- RESET_PC, default 32'h0000_0000: fetch PC after reset; word aligned.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tab_inst  input  32 × N_INST (unpacked array)  instruction table, word i holds the instruction at PC 4·i.
- redirect_i  input  1  flush queue and restart fetch at redirect_pc_i.
- redirect_pc_i  input  32  new fetch address.
- inst_ready_i  input  1  decode accepts the head entry.
- inst_valid_o  output  1  head entry is valid.
- inst_o  output  32  head instruction.
- inst_pc_o  output  32  PC of the head instruction.
- inst_pc4_o  output  32  inst_pc_o + 4, feeds the wb_sel PC+4 path.
- fault_o  output  1  head entry is a fetch fault.
- count_o  output  $clog2(Q_DEPTH)+1  current queue occupancy.

## Operation
- Fetch PC register `fpc`, fetch-enable flag `halted`, queue of entries {inst, pc, fault}.
- Fetch index = fpc[31:2]. A fetch is bad if fpc[1:0] ≠ 0 or index ≥ N_INST.
- Push condition: !halted && (count < Q_DEPTH || pop) && !redirect_i.
- Each push advances fpc by 4, modulo 2^32.
- Good fetch pushes {tab_inst[index], fpc, 0}.
- Bad fetch pushes {32'h0000_0013 (NOP), fpc, 1} and sets halted. No further pushes happen until a redirect.
- Pop = inst_valid_o && inst_ready_i.
- inst_valid_o = (count ≠ 0) && !redirect_i, so no pop occurs in a redirect cycle.
- Head outputs are held stable while inst_valid_o=1 and inst_ready_i=0.
- Redirect has priority over push and pop:
  - count ← 0, both pointers ← 0.
  - fpc ← redirect_pc_i, halted ← 0.
  - A misaligned redirect_pc_i produces one fault entry on the next push.
- Pointers are $clog2(Q_DEPTH) bits and wrap naturally.
- count = count + push − pop; it never exceeds Q_DEPTH and never underflows.
- Full with a same-cycle pop: the push is accepted and count stays at Q_DEPTH.
- Empty: inst_valid_o=0. Head data is don't-care but must not be X after reset.

## Timing
- Reset values:
  - inst_valid_o=0, fault_o=0, count_o=0.
  - inst_o=0, inst_pc_o=0, inst_pc4_o=4 (queue storage cleared).
  - fpc=RESET_PC, halted=0.
- Reset asserted mid-operation discards the queue contents and any pending redirect.
- Table read is combinational and the queue write is registered. The first entry after reset deassertion is pushed at the first rising edge and is valid in the following cycle. Fetch-to-valid latency is 1 cycle.
- Redirect sampled at edge t, first new entry valid in cycle t+2:
  - Edge t: flush.
  - Cycle t+1: fetch tab_inst[redirect_pc_i>>2].
  - Edge t+1: push.
- Sustained throughput: 1 instruction per cycle while inst_ready_i=1 and fetch is not halted.
- Backpressure: with inst_ready_i=0 the queue fills to Q_DEPTH within Q_DEPTH cycles, then fpc freezes.

## Structure
- Package riscv_fetch_pkg:
  - RV_NOP = 32'h0000_0013.
  - fetch_entry_t packed struct {logic [31:0] inst; logic [31:0] pc; logic fault;}.
- Sub-module fetch_fifo:
  - Generic DEPTH × fetch_entry_t circular buffer.
  - Ports: push, pop, flush, din, dout, count.
  - Async-reset pointers and count.
- Top level holds fpc, halted, bad-fetch detection, and the handshake gating.

## Test plan
- Reset, tab_inst[0..3]={0x00500093, 0x00100113, 0x002081B3, 0x00000013}, inst_ready_i=1 → inst_valid_o=1 from cycle 2. Entries appear in order with inst_pc_o=0, 4, 8, 0xC and inst_pc4_o=4, 8, 0xC, 0x10.
- inst_ready_i=0 for 10 cycles, Q_DEPTH=4 → count_o reaches 4, head stays PC 0, fpc frozen at 0x10. Raise ready → PCs 0, 4, 8, 0xC, 0x10 delivered back-to-back, none lost or duplicated.
- Redirect to 0x20 while count_o=3 → count_o=0 next cycle, inst_valid_o=0 in the redirect cycle and the next, then head inst_pc_o=0x20, inst_o=tab_inst[8].
- N_INST=21, run off the end → entry PC 0x54 has fault_o=1, inst_o=0x00000013, and no further entries arrive. Redirect to 0x0 resumes normal fetch.
- Redirect to 0x6 → single entry with fault_o=1, inst_pc_o=0x6, then halted.
- Assert rst while count_o=4 and inst_valid_o=1 → all outputs reach their reset values asynchronously. After release, fetch restarts at RESET_PC.
